// File: rtl/img_pkg.sv
// Shared definitions for the image-processing pipeline: operation codes,
// frame scheduler state encoding and the width of its delay counters.
package img_pkg;

    // Per-frame pixel operation selected by the granted requester.
    localparam logic [1:0] OP_BRIGHT_ADD = 2'b00;
    localparam logic [1:0] OP_BRIGHT_SUB = 2'b01;
    localparam logic [1:0] OP_INVERT     = 2'b10;
    localparam logic [1:0] OP_THRESHOLD  = 2'b11;

    // VSYNC and HSYNC delay counters; delay parameters must fit in this width.
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StGap,
        StData,
        StDone
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a
// rotating pointer; the pointer moves past the winner when a grant is taken.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] pos;
    logic          found;

    // Scan from the pointer upward, wrapping, and take the first request seen.
    always_comb begin
        gnt   = '0;
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = IW'((32'(ptr_q) + i) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                index    = pos;
            end
        end
    end

    // Winner becomes lowest priority for the next arbitration.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ptr_q <= '0;
        end else if (advance && |req) begin
            ptr_q <= (32'(index) == N - 1) ? '0 : index + IW'(1);
        end
    end

endmodule

// File: rtl/img_frame_sched.sv
// Frame scheduler: arbitrates frame requests, latches the winner's operation
// and walks one frame (VSYNC period, per-line gap, pixel-pair addresses with
// backpressure). Build option SCHED_ABORT_EN enables the abort input.
module img_frame_sched
    import img_pkg::*;
#(
    parameter int unsigned WIDTH          = 768,
    parameter int unsigned HEIGH          = 512,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned START_UP_DELAY = 100,
    parameter int unsigned HSYNC_DELAY    = 160,
    localparam int unsigned RW = $clog2(HEIGH),
    localparam int unsigned CW = $clog2(WIDTH),
    localparam int unsigned IW = $clog2(NUM_REQ)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*2-1:0]   req_op,
    input  logic [NUM_REQ*8-1:0]   req_value,
    input  logic                   abort,
    input  logic                   out_ready,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   aborted,
    output logic                   busy,
    output logic [1:0]             cfg_op,
    output logic [7:0]             cfg_value,
    output logic                   VSYNC,
    output logic                   HSYNC,
    output logic                   pix_valid,
    output logic [RW-1:0]          pix_row,
    output logic [CW-1:0]          pix_col
);

    localparam logic [CNT_W-1:0] VsyncLast = CNT_W'(START_UP_DELAY);
    localparam logic [CNT_W-1:0] GapLast   = CNT_W'(HSYNC_DELAY);
    localparam logic [CW-1:0]    ColLast   = CW'(WIDTH - 2);
    localparam logic [RW-1:0]    RowLast   = RW'(HEIGH - 1);

    sched_state_e       state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RW-1:0]      row_q;
    logic [CW-1:0]      col_q;
    logic [IW-1:0]      winner_q;
    logic [NUM_REQ-1:0] done_q;
    logic               aborted_q;
    logic [1:0]         cfg_op_q;
    logic [7:0]         cfg_value_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               abort_hit;
    logic [1:0]         op_lane  [NUM_REQ];
    logic [7:0]         val_lane [NUM_REQ];

`ifdef SCHED_ABORT_EN
    assign abort_hit = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign op_lane[g]  = req_op[2*g +: 2];
        assign val_lane[g] = req_value[8*g +: 8];
    end

    // Requests are only considered while idle.
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .req     (req_valid),
        .advance (state_q == StIdle),
        .gnt     (arb_gnt),
        .index   (arb_idx)
    );

    assign win_onehot = NUM_REQ'(1) << winner_q;

    // Frame sequencer: grant latch, delay counting, pixel-pair walk, completion pulse.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            winner_q    <= '0;
            done_q      <= '0;
            aborted_q   <= 1'b0;
            cfg_op_q    <= '0;
            cfg_value_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        winner_q    <= arb_idx;
                        cfg_op_q    <= op_lane[arb_idx];
                        cfg_value_q <= val_lane[arb_idx];
                        cnt_q       <= '0;
                        state_q     <= StVsync;
                    end
                end
                StVsync: begin
                    if (abort_hit) begin
                        done_q    <= win_onehot;
                        aborted_q <= 1'b1;
                        state_q   <= StDone;
                    end else if (cnt_q == VsyncLast) begin
                        cnt_q   <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StGap: begin
                    if (abort_hit) begin
                        done_q    <= win_onehot;
                        aborted_q <= 1'b1;
                        state_q   <= StDone;
                    end else if (cnt_q == GapLast) begin
                        cnt_q   <= '0;
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StData: begin
                    // Abort wins over a beat completing in the same cycle.
                    if (abort_hit) begin
                        done_q    <= win_onehot;
                        aborted_q <= 1'b1;
                        state_q   <= StDone;
                    end else if (out_ready) begin
                        if (col_q == ColLast) begin
                            col_q <= '0;
                            if (row_q == RowLast) begin
                                done_q  <= win_onehot;
                                state_q <= StDone;
                            end else begin
                                row_q   <= row_q + RW'(1);
                                state_q <= StGap;
                            end
                        end else begin
                            col_q <= col_q + CW'(2);
                        end
                    end
                end
                StDone: begin
                    done_q    <= '0;
                    aborted_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Grant is shown in the idle cycle itself so VSYNC begins on the next one.
    assign gnt       = (HRESETn && state_q == StIdle) ? arb_gnt : '0;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign busy      = (state_q != StIdle);
    assign cfg_op    = cfg_op_q;
    assign cfg_value = cfg_value_q;
    assign VSYNC     = (state_q == StVsync);
    assign HSYNC     = (state_q == StData);
    assign pix_valid = (state_q == StData);
    assign pix_row   = row_q;
    assign pix_col   = col_q;

endmodule

// File: tb/tb_img_frame_sched.sv
// Bench for img_frame_sched: per-cycle timeline reference model plus
// table-driven frames, hand-written corner sequences and randomized frames.
module tb_img_frame_sched;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int SUD = 3;
    localparam int HD  = 2;
    localparam int NR  = 4;
    localparam int HB  = W / 2;
    localparam int TOT = HB * H;
`ifdef SCHED_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic [NR-1:0]   req_valid;
    logic [NR*2-1:0] req_op;
    logic [NR*8-1:0] req_value;
    logic            abort;
    logic            out_ready;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic            aborted;
    logic            busy;
    logic [1:0]      cfg_op;
    logic [7:0]      cfg_value;
    logic            VSYNC;
    logic            HSYNC;
    logic            pix_valid;
    logic [1:0]      pix_row;
    logic [2:0]      pix_col;

    img_frame_sched #(
        .WIDTH          (W),
        .HEIGH          (H),
        .NUM_REQ        (NR),
        .START_UP_DELAY (SUD),
        .HSYNC_DELAY    (HD)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_value (req_value),
        .abort     (abort),
        .out_ready (out_ready),
        .gnt       (gnt),
        .done      (done),
        .aborted   (aborted),
        .busy      (busy),
        .cfg_op    (cfg_op),
        .cfg_value (cfg_value),
        .VSYNC     (VSYNC),
        .HSYNC     (HSYNC),
        .pix_valid (pix_valid),
        .pix_row   (pix_row),
        .pix_col   (pix_col)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    bit rnd     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic fail_timeout(input string name);
        n_total++;
        $display("FAIL %s: event not seen within budget (actual none, required one) cycle %0d",
                 name, cyc);
    endtask

    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int i = 0; i < NR; i++) if (r[(p + i) % NR]) return (p + i) % NR;
        return 0;
    endfunction

    // Reference model state: a frame is a timeline anchored at the grant cycle.
    bit   m_active;
    int   m_t, m_k, m_wait, m_done_at, m_ptr, m_idx;
    bit   m_ab;
    logic [1:0] m_op;
    logic [7:0] m_val;
    // Observations for the directed sequences.
    int   gnt_cnt = 0, done_cnt = 0, obs_gnt_cyc, obs_done_cyc;
    logic [NR-1:0] obs_gnt, obs_done;
    logic obs_ab;
    logic [1:0] obs_op;
    logic [7:0] obs_val;

    initial begin : monitor
        bit was_active, in_done, e_pv, e_vs, e_ab;
        logic [NR-1:0] e_gnt, e_done;
        logic [1:0] e_row, e_op;
        logic [2:0] e_col;
        logic [7:0] e_val;
        logic [31:0] expv, actv;
        int idx;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                m_active = 0; m_ptr = 0; m_op = '0; m_val = '0; m_ab = 0; m_done_at = -100;
                actv = 32'({gnt, done, aborted, busy, VSYNC, HSYNC, pix_valid, pix_row,
                            pix_col, cfg_op, cfg_value});
                check("reset_outputs", actv, 32'h0);
            end else begin
                was_active = m_active;
                in_done = m_active && (cyc == m_done_at);
                e_gnt = '0; e_done = '0; e_ab = 0; e_pv = 0; e_vs = 0;
                e_row = '0; e_col = '0; e_op = m_op; e_val = m_val;
                if (!m_active) begin
                    if (|req_valid) begin
                        idx = rr_pick(req_valid, m_ptr);
                        e_gnt = 4'(1) << idx;
                        m_active = 1; m_t = cyc; m_k = 0; m_wait = cyc + SUD + HD + 3;
                        m_done_at = cyc + 100000; m_ab = 0; m_idx = idx;
                        m_ptr = (idx + 1) % NR;
                        m_op = req_op[2*idx +: 2];
                        m_val = req_value[8*idx +: 8];
                    end
                end else if (in_done) begin
                    e_done = 4'(1) << m_idx;
                    e_ab = m_ab;
                    m_active = 0;
                end else begin
                    e_vs = (cyc <= m_t + SUD + 1);
                    e_pv = (cyc >= m_wait);
                    if (e_pv) begin
                        e_row = 2'(m_k / HB);
                        e_col = 3'(2 * (m_k % HB));
                    end
                    if (ABORT_EN && abort) begin
                        m_done_at = cyc + 1; m_ab = 1;
                    end else if (e_pv && out_ready) begin
                        m_k++;
                        if (m_k % HB == 0) begin
                            if (m_k == TOT) m_done_at = cyc + 1;
                            else m_wait = cyc + HD + 2;
                        end
                    end
                end
                expv = 32'({e_gnt, e_done, e_ab, was_active, e_vs, e_pv, e_pv, e_row, e_col,
                            e_op, e_val});
                actv = 32'({gnt, done, aborted, busy, VSYNC, HSYNC, pix_valid,
                            e_pv ? pix_row : 2'b0, e_pv ? pix_col : 3'b0, cfg_op, cfg_value});
                check("cycle_outputs", actv, expv);
                if (|gnt) begin gnt_cnt++; obs_gnt = gnt; obs_gnt_cyc = cyc; end
                if (|done) begin
                    done_cnt++; obs_done = done; obs_done_cyc = cyc; obs_ab = aborted;
                    obs_op = cfg_op; obs_val = cfg_value;
                end
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
        if (rnd) begin
            out_ready = ($urandom_range(0, 9) < 7);
            abort = ($urandom_range(0, 149) == 0);
        end
    endtask

    task automatic wait_gnt(input int prev, input string name);
        int n = 0;
        while (gnt_cnt == prev && n < 40) begin tick(); n++; end
        if (gnt_cnt == prev) fail_timeout(name);
    endtask

    task automatic wait_done(input int prev, input string name);
        int n = 0;
        while (done_cnt == prev && n < 400) begin tick(); n++; end
        if (done_cnt == prev) fail_timeout(name);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [1:0] op;
        logic [7:0] val;
        logic [3:0] gnt;
        int         len;
    } vec_t;

    vec_t vt [7];
    logic [3:0] rr_exp [5];

    initial begin : stim
        int pg, pd, t, last_done, exp_len;
        HRESETn = 0; req_valid = '0; req_op = '0; req_value = '0; abort = 0; out_ready = 1;
        vt[0] = '{4'b0010, 2'b11, 8'd90, 4'b0010, 33};
        vt[1] = '{4'b1111, 2'b00, 8'd10, 4'b0100, 33};
        vt[2] = '{4'b1111, 2'b01, 8'd20, 4'b1000, 33};
        vt[3] = '{4'b1111, 2'b10, 8'd30, 4'b0001, 33};
        vt[4] = '{4'b0001, 2'b00, 8'd40, 4'b0001, 33};
        vt[5] = '{4'b1010, 2'b11, 8'd50, 4'b0010, 33};
        vt[6] = '{4'b1011, 2'b01, 8'd60, 4'b1000, 33};
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1;
        // Abort while idle must have no effect.
        tick(); abort = 1; tick(); abort = 0; tick();

        // Table-driven frames; losing lanes carry inverted op/value.
        for (int i = 0; i < 7; i++) begin
            for (int l = 0; l < NR; l++) begin
                req_op[2*l +: 2]    = vt[i].gnt[l] ? vt[i].op : ~vt[i].op;
                req_value[8*l +: 8] = vt[i].gnt[l] ? vt[i].val : ~vt[i].val;
            end
            pg = gnt_cnt; pd = done_cnt;
            req_valid = vt[i].req;
            wait_gnt(pg, "tbl_gnt_wait");
            req_valid = '0;
            check("tbl_gnt", 32'(obs_gnt), 32'(vt[i].gnt));
            wait_done(pd, "tbl_done_wait");
            check("tbl_done", 32'(obs_done), 32'(vt[i].gnt));
            check("tbl_len", 32'(obs_done_cyc - obs_gnt_cyc), 32'(vt[i].len));
            check("tbl_cfg", 32'({obs_op, obs_val}), 32'({vt[i].op, vt[i].val}));
            check("tbl_aborted", 32'(obs_ab), 32'(0));
        end

        // Round-robin with all requests held: back-to-back frames, one idle cycle apart.
        for (int l = 0; l < NR; l++) begin
            req_op[2*l +: 2] = 2'(l);
            req_value[8*l +: 8] = 8'(16 * l);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            pg = gnt_cnt; pd = done_cnt; last_done = obs_done_cyc;
            wait_gnt(pg, "rr_gnt_wait");
            if (k == 4) req_valid = '0;
            check("rr_gnt", 32'(obs_gnt), 32'(rr_exp[k]));
            if (k > 0) check("rr_idle_gap", 32'(obs_gnt_cyc), 32'(last_done + 1));
            wait_done(pd, "rr_done_wait");
        end

        // Backpressure: stall 5 cycles on the row1/col4 beat.
        pg = gnt_cnt; pd = done_cnt;
        req_valid = 4'b0100;
        wait_gnt(pg, "bp_gnt_wait");
        req_valid = '0;
        t = obs_gnt_cyc;
        check("bp_gnt", 32'(obs_gnt), 32'(4'b0100));
        while (cyc < t + 17) tick();
        out_ready = 0;
        while (cyc < t + 22) tick();
        out_ready = 1;
        wait_done(pd, "bp_done_wait");
        check("bp_len", 32'(obs_done_cyc - obs_gnt_cyc), 32'(38));

        // Abort pulse on the second beat of row 2.
        pg = gnt_cnt; pd = done_cnt;
        req_valid = 4'b0001;
        wait_gnt(pg, "ab_gnt_wait");
        req_valid = '0;
        t = obs_gnt_cyc;
        while (cyc < t + 23) tick();
        abort = 1;
        tick();
        abort = 0;
        wait_done(pd, "ab_done_wait");
        exp_len = ABORT_EN ? 24 : 33;
        check("ab_len", 32'(obs_done_cyc - obs_gnt_cyc), 32'(exp_len));
        check("ab_flag", 32'(obs_ab), 32'(ABORT_EN));
        check("ab_done", 32'(obs_done), 32'(4'b0001));

        // Asynchronous reset in the middle of DATA; pointer must restart at 0.
        pg = gnt_cnt; pd = done_cnt;
        req_valid = 4'b0010;
        wait_gnt(pg, "rst_gnt_wait");
        req_valid = '0;
        check("rst_pre_gnt", 32'(obs_gnt), 32'(4'b0010));
        t = obs_gnt_cyc;
        while (cyc < t + 10) tick();
        #2 HRESETn = 0;
        tick(); tick();
        HRESETn = 1;
        tick();
        check("rst_no_done", 32'(done_cnt), 32'(pd));
        pg = gnt_cnt;
        req_valid = 4'b1111;
        wait_gnt(pg, "rst_regnt_wait");
        req_valid = '0;
        check("rst_regnt", 32'(obs_gnt), 32'(4'b0001));
        wait_done(pd, "rst_done_wait");

        // Randomized frames: random masks, pending requests, stalls and aborts.
        rnd = 1;
        for (int f = 0; f < 25; f++) begin
            for (int l = 0; l < NR; l++) begin
                req_op[2*l +: 2]    = 2'($urandom_range(0, 3));
                req_value[8*l +: 8] = 8'($urandom_range(0, 255));
            end
            pg = gnt_cnt; pd = done_cnt;
            req_valid = 4'($urandom_range(1, 15));
            wait_gnt(pg, "rnd_gnt_wait");
            req_valid = 4'($urandom_range(0, 15));
            wait_done(pd, "rnd_done_wait");
            check("rnd_done_to_winner", 32'(obs_done), 32'(obs_gnt));
            req_valid = '0;
        end
        rnd = 0; out_ready = 1; abort = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
